// File: rtl/vga_sched_pkg.sv
// -----------------------------------------------------------------------------
// vga_sched_pkg
//
// Shared definitions for the VGA update scheduler:
//   - sched_state_e : scheduler FSM states (wait, arbitrate, grant, release)
//   - VGA 640x480 frame geometry constants used to size defaults
//   - DEFAULT_TIMEOUT : default maximum grant length (two full lines)
//   - idx_width()     : index width for an N-entry one-hot vector (min 1 bit)
// -----------------------------------------------------------------------------
package vga_sched_pkg;

    typedef enum logic [1:0] {
        StWait    = 2'd0,
        StArb     = 2'd1,
        StGrant   = 2'd2,
        StRelease = 2'd3
    } sched_state_e;

    // 640x480 timing: pixel clocks per line, lines per frame, visible lines.
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned V_ACTIVE = 480;

    // Two full lines; long enough for any single requester's update burst.
    localparam int unsigned DEFAULT_TIMEOUT = 2 * H_TOTAL;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Combinational round-robin pick. Selects the first set request bit at or
// above ptr_i, wrapping around to bit 0 when nothing at or above ptr_i is set.
//
// Parameters:
//   N        : number of request lines
// Ports:
//   req_i    : request vector
//   ptr_i    : highest-priority index for this pick
//   winner_o : one-hot winner (zero when no request)
//   index_o  : binary index of the winner (zero when no request)
//   valid_o  : a winner exists
// -----------------------------------------------------------------------------
module rr_arbiter
    import vga_sched_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    winner_o,
    output logic [IdxW-1:0] index_o,
    output logic            valid_o
);

    logic [N-1:0] upper_mask;
    logic [N-1:0] upper_req;

    // Requests at or above the pointer get first look.
    always_comb begin
        upper_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            upper_mask[i] = (IdxW'(i) >= ptr_i);
        end
        upper_req = req_i & upper_mask;
    end

    always_comb begin
        winner_o = '0;
        index_o  = '0;
        valid_o  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_o && upper_req[i]) begin
                valid_o     = 1'b1;
                index_o     = IdxW'(i);
                winner_o[i] = 1'b1;
            end
        end
        // Wrap: nothing at or above the pointer, take the lowest request.
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o     = 1'b1;
                index_o     = IdxW'(i);
                winner_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_update_scheduler.sv
// -----------------------------------------------------------------------------
// vga_update_scheduler
//
// Hands out exclusive, one-hot access to shared pixel-source state so that
// front-end requesters (price, icons, status text, coin feedback) only change
// it during vertical blanking. Requesters hold a level request and release
// with a one-cycle done pulse; access is round-robin and the pointer persists
// across frames. Also counts frames (rising edges of registered vblank).
//
// Configuration macro:
//   SCHED_TIMEOUT_EN : when defined, a grant is forcibly revoked (with a
//                      one-cycle timeout_err_o) after TIMEOUT_CYCLES cycles or
//                      as soon as blanking ends (tear guard). When undefined,
//                      a grant is held until done or request drop and
//                      timeout_err_o stays low.
//
// Parameters:
//   N_REQ          : number of requesters (2..8)
//   TIMEOUT_CYCLES : maximum grant length, SCHED_TIMEOUT_EN builds only
//   FCNT_W         : frame counter width
// Ports:
//   clk_i          : pixel clock
//   rst_ni         : synchronous active-low reset
//   vblank_i       : high outside the active rows (from timing generator)
//   req_i          : per-requester level request
//   done_i         : per-requester completion pulse (granted requester only)
//   grant_o        : one-hot or zero grant
//   busy_o         : scheduler is arbitrating, granting or releasing
//   timeout_err_o  : one-cycle pulse when a grant is revoked
//   frame_cnt_o    : wrapping count of vblank rising edges
// -----------------------------------------------------------------------------
module vga_update_scheduler
    import vga_sched_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned FCNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vblank_i,
    input  logic [N_REQ-1:0]  req_i,
    input  logic [N_REQ-1:0]  done_i,
    output logic [N_REQ-1:0]  grant_o,
    output logic              busy_o,
    output logic              timeout_err_o,
    output logic [FCNT_W-1:0] frame_cnt_o
);

    localparam int unsigned IdxW = idx_width(N_REQ);

    // ---------------------------------------------------------------------
    // Blanking edge detect and frame counter
    // ---------------------------------------------------------------------
    logic              vb_q;
    logic              vb_qq;
    logic [FCNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vb_q        <= 1'b0;
            vb_qq       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vb_q  <= vblank_i;
            vb_qq <= vb_q;
            if (vb_q && !vb_qq) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    sched_state_e     state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IdxW-1:0]  owner_q;
    logic [IdxW-1:0]  ptr_q;
    logic             busy_q;
    logic             tmo_err_q;

    logic [N_REQ-1:0] arb_winner;
    logic [IdxW-1:0]  arb_index;
    logic             arb_valid;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (arb_winner),
        .index_o  (arb_index),
        .valid_o  (arb_valid)
    );

    logic any_req;
    logic owner_done;
    logic owner_req;
    logic revoke;

    assign any_req    = |req_i;
    assign owner_done = done_i[owner_q];
    assign owner_req  = req_i[owner_q];

    // ---------------------------------------------------------------------
    // Forced revoke: grant age limit and tear guard
    // ---------------------------------------------------------------------
`ifdef SCHED_TIMEOUT_EN
    // One spare bit so the counter can saturate past TIMEOUT_CYCLES-1.
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == StArb) begin
            cnt_q <= '0;
        end else if (state_q == StGrant && cnt_q != '1) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign revoke = (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) || !vb_q;
`else
    // Grants run to completion; the error flop below never sets.
    assign revoke = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StWait;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= 1'b0;
            unique case (state_q)
                StWait: begin
                    if (vb_q && any_req) begin
                        state_q <= StArb;
                        busy_q  <= 1'b1;
                    end
                end
                StArb: begin
                    if (!vb_q || !arb_valid) begin
                        state_q <= StWait;
                        busy_q  <= 1'b0;
                    end else begin
                        grant_q <= arb_winner;
                        owner_q <= arb_index;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    // Normal completion (done or request withdrawn) takes
                    // priority over a forced revoke in the same cycle.
                    if (owner_done || !owner_req) begin
                        grant_q <= '0;
                        state_q <= StRelease;
                    end else if (revoke) begin
                        grant_q   <= '0;
                        tmo_err_q <= 1'b1;
                        state_q   <= StRelease;
                    end
                end
                StRelease: begin
                    ptr_q <= (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
                    if (vb_q && any_req) begin
                        state_q <= StArb;
                    end else begin
                        state_q <= StWait;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StWait;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = tmo_err_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_update_scheduler
//
// Directed bench for vga_update_scheduler (N_REQ=4, TIMEOUT_CYCLES=64,
// FCNT_W=4). A behavioural model of the scheduling rules is stepped on every
// clock edge and compared against the DUT on every falling edge; directed
// sequences add hand-computed literal expectations. Honours SCHED_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_vga_update_scheduler;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 64;
    localparam int unsigned FW  = 4;
`ifdef SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          vblank = 1'b0;
    logic [N-1:0]  req    = '0;
    logic [N-1:0]  done   = '0;
    logic [N-1:0]  grant;
    logic          busy;
    logic          terr;
    logic [FW-1:0] fcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_update_scheduler #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TMO),
        .FCNT_W         (FW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .vblank_i      (vblank),
        .req_i         (req),
        .done_i        (done),
        .grant_o       (grant),
        .busy_o        (busy),
        .timeout_err_o (terr),
        .frame_cnt_o   (fcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model. Phases: 0 idle, 1 choosing, 2 owner active, 3 cooling down.
    // ------------------------------------------------------------------
    bit m_vb1, m_vb2, m_err;
    int m_fc, m_ph, m_own, m_ptr, m_age;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_vb1 = 0; m_vb2 = 0; m_err = 0;
            m_fc = 0; m_ph = 0; m_own = -1; m_ptr = 0; m_age = 0;
        end else begin
            if (m_vb1 && !m_vb2) m_fc = (m_fc + 1) % (1 << FW);
            m_err = 0;
            case (m_ph)
                0: if (m_vb1 && req != 0) m_ph = 1;
                1: begin
                    if (!m_vb1 || req == 0) m_ph = 0;
                    else begin
                        m_own = pick(req, m_ptr);
                        m_age = 0;
                        m_ph  = 2;
                    end
                end
                2: begin
                    if (done[m_own] || !req[m_own]) m_ph = 3;
                    else if (TMO_EN && (m_age == TMO - 1 || !m_vb1)) begin
                        m_ph  = 3;
                        m_err = 1;
                    end
                    m_age++;
                end
                default: begin
                    m_ptr = (m_own + 1) % N;
                    m_ph  = (m_vb1 && req != 0) ? 1 : 0;
                end
            endcase
            m_vb2 = m_vb1;
            m_vb1 = vblank;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("m_grant", grant, (m_ph == 2) ? (32'd1 << m_own) : 32'd0);
            chk("m_busy", busy, (m_ph != 0) ? 1 : 0);
            chk("m_terr", terr, m_err);
            chk("m_fcnt", fcnt, m_fc);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int maxc, output int zeros);
        zeros = 0;
        while (grant == '0 && zeros < maxc) begin
            zeros++;
            tick(1);
        end
        chk("wait_grant", (grant != '0) ? 1 : 0, 1);
    endtask

    task automatic pulse_done();
        done = grant;
        tick(1);
        done = '0;
    endtask

    logic [N-1:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros;
        int cnt;
        bit any_g;

        // Reset and idle with everything requesting inside blanking.
        rst_n = 0; req = 4'b1111; vblank = 1;
        tick(4);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fcnt", fcnt, 0);
        rst_n = 1;
        tick(2);
        chk("rst_lat2", grant, 0);
        tick(1);
        chk("rst_lat3", grant, 4'b0001);
        chk("rst_busy_on", busy, 1);
        pulse_done();
        req = '0;

        // Round-robin over 0,1,3 with the pointer reset to 0.
        rst_n = 0;
        tick(2);
        rst_n = 1; req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_grant(20, zeros);
            chk("rr_order", grant, rr_exp[k]);
            if (k > 0) chk("rr_gap", zeros, 2);
            tick(10);
            pulse_done();
        end
        req = '0;

        // Active video: nothing granted however long the request waits.
        vblank = 0;
        tick(3);
        req = 4'b0100;
        any_g = 0;
        for (int k = 0; k < 2000; k++) begin
            tick(1);
            if (grant != '0) any_g = 1;
        end
        chk("active_nogrant", any_g, 0);
        chk("fcnt_before", fcnt, 1);
        vblank = 1;
        tick(2);
        chk("vb_lat2", grant, 0);
        tick(1);
        chk("vb_lat3", grant, 4'b0100);
        chk("fcnt_inc", fcnt, 2);

        // Requester 2 never finishes; requester 3 is waiting behind it.
        req = 4'b1100;
        if (TMO_EN) begin
            cnt = 1;
            while (grant != '0 && cnt < 200) begin
                tick(1);
                if (grant != '0) cnt++;
            end
            chk("tmo_len", cnt, TMO);
            chk("tmo_err", terr, 1);
            tick(1);
            chk("tmo_err_once", terr, 0);
        end else begin
            tick(100);
            chk("hold_grant", grant, 4'b0100);
            chk("hold_noerr", terr, 0);
            pulse_done();
        end
        wait_grant(10, zeros);
        chk("after_tmo_next", grant, 4'b1000);
        pulse_done();
        req = '0;

        // Blanking ends five cycles into a grant.
        req = 4'b0001;
        wait_grant(10, zeros);
        chk("tear_owner", grant, 4'b0001);
        tick(4);
        vblank = 0;
        tick(1);
        chk("tear_still", grant, 4'b0001);
        tick(1);
        if (TMO_EN) begin
            chk("tear_drop", grant, 0);
            chk("tear_err", terr, 1);
        end else begin
            chk("tear_hold", grant, 4'b0001);
            chk("tear_noerr", terr, 0);
            tick(20);
            chk("tear_hold_late", grant, 4'b0001);
            pulse_done();
        end
        req = '0;
        tick(2);

        // done on the same cycle the age limit would fire.
        vblank = 1;
        req = 4'b0010;
        wait_grant(10, zeros);
        chk("race_owner", grant, 4'b0010);
        tick(TMO - 1);
        chk("race_pre", grant, 4'b0010);
        done = 4'b0010;
        tick(1);
        done = '0;
        chk("race_drop", grant, 0);
        chk("race_noerr", terr, 0);
        req = '0;
        tick(2);

        // Frame counter wrap over 17 blanking pulses.
        rst_n = 0; vblank = 0;
        tick(3);
        rst_n = 1;
        chk("wrap_start", fcnt, 0);
        for (int k = 1; k <= 17; k++) begin
            vblank = 1;
            tick(4);
            vblank = 0;
            tick(4);
            chk("fcnt_wrap", fcnt, k % 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
